// File: rtl/dp_mem_responder.sv
// Memory-side responder: serves instruction fetches and data loads/stores
// from the datapath over one single-ported RAM. Data requests win over
// fetches. A one-entry instruction buffer answers repeated fetches with no
// latency. A watchdog forces stuck RAM accesses to complete with an error.
module dp_mem_responder #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 TIMEOUT  = 64,
  parameter logic [DATA_W-1:0]  ERR_WORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  input  logic              halt,
  output logic              flushed,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC, HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_store;
  logic              req_wen;
  logic [CNT_W-1:0]  wait_cnt;
  logic              ibuf_valid;
  logic [ADDR_W-1:0] ibuf_tag;
  logic [DATA_W-1:0] ibuf_data;
  logic              ihit_q, dhit_q, err_q;
  logic [DATA_W-1:0] imemload_q, dmemload_q;

  logic in_acc, timeout, done, still_req;
  logic accept_d, accept_i, ibuf_serve;

  // Access status: completion by RAM or by watchdog, and whether the
  // datapath still wants the result.
  always_comb begin
    in_acc    = (state == DACC) || (state == IACC);
    timeout   = in_acc && !ram_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
    done      = in_acc && (ram_ready || timeout);
    still_req = (state == DACC) ? (req_wen ? dmemWEN : dmemREN) : imemREN;
  end

  // State register; reset abandons any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state, request acceptance and all outputs.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_nx   = state;
    accept_d   = 1'b0;
    accept_i   = 1'b0;
    ibuf_serve = 1'b0;
    unique case (state)
      IDLE: begin
        if (halt) begin
          state_nx = HALT;
        end else if (dmemREN || dmemWEN) begin
          accept_d = 1'b1;
          state_nx = DACC;
        end else if (imemREN) begin
          if (ibuf_valid && (ibuf_tag == imemaddr)) begin
            ibuf_serve = 1'b1;
          end else begin
            accept_i = 1'b1;
            state_nx = IACC;
          end
        end
      end
      DACC, IACC: if (done) state_nx = IDLE;
      HALT:       state_nx = HALT;
      default:    state_nx = IDLE;
    endcase

    ramREN   = (state == IACC) || ((state == DACC) && !req_wen);
    ramWEN   = (state == DACC) && req_wen;
    ramaddr  = in_acc ? req_addr : '0;
    ramstore = ((state == DACC) && req_wen) ? req_store : '0;
    ihit     = ihit_q || ibuf_serve;
    imemload = ibuf_serve ? ibuf_data : imemload_q;
    dhit     = dhit_q;
    dmemload = dmemload_q;
    flushed  = (state == HALT);
    err      = err_q;
  end

  // Request latch, wait counter, instruction buffer, hit pulses and
  // returned data. The buffer is tiny, so its contents reset with the rest.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_addr   <= '0;
      req_store  <= '0;
      req_wen    <= 1'b0;
      wait_cnt   <= '0;
      ibuf_valid <= 1'b0;
      ibuf_tag   <= '0;
      ibuf_data  <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      wait_cnt <= (in_acc && !done) ? wait_cnt + CNT_W'(1) : '0;

      if (accept_d) begin
        req_addr  <= dmemaddr;
        req_store <= dmemstore;
        req_wen   <= dmemWEN;
        // A store to the buffered address makes the buffered word stale.
        if (dmemWEN && (dmemaddr == ibuf_tag)) ibuf_valid <= 1'b0;
      end
      if (accept_i)   req_addr   <= imemaddr;
      if (ibuf_serve) imemload_q <= ibuf_data;

      if (done) begin
        if (timeout) err_q <= 1'b1;
        if (state == DACC) begin
          dhit_q <= still_req;
          if (still_req && !req_wen) dmemload_q <= timeout ? ERR_WORD : ramload;
        end else begin
          ihit_q <= still_req;
          if (still_req) imemload_q <= timeout ? ERR_WORD : ramload;
          if (!timeout) begin
            ibuf_valid <= 1'b1;
            ibuf_tag   <= req_addr;
            ibuf_data  <= ramload;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder: a per-cycle vector table for the
// fetch/ibuf/store-invalidate/load flow, then hand-written sequences for
// withdrawn fetch, timeout, halt and mid-access reset.
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN, dmemREN, dmemWEN, halt, ram_ready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic        ihit, dhit, flushed, ramREN, ramWEN, err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  dp_mem_responder dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .halt(halt), .flushed(flushed),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] ds;
    logic        rdy;
    logic [31:0] rl;
    logic        e_ihit;
    logic [31:0] e_il;
    logic        e_dhit;
    logic [31:0] e_dl;
    logic        e_rr;
    logic        e_rw;
    logic [31:0] e_ra;
    logic [31:0] e_rs;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    int n;
    int viol;

    // ir ia dr dw da ds rdy rl | ihit il dhit dl rr rw ra rs
    vec[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,             0, 0,            0, 0,            0, 0, 0, 0};
    vec[1]  = '{1, 0, 0, 0, 0, 0, 0, 0,             0, 0,            0, 0,            1, 0, 0, 0};
    vec[2]  = '{1, 0, 0, 0, 0, 0, 0, 0,             0, 0,            0, 0,            1, 0, 0, 0};
    vec[3]  = '{1, 0, 0, 0, 0, 0, 1, 32'h8C220004,  0, 0,            0, 0,            1, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h8C220004, 0, 0,            0, 0, 0, 0};
    vec[5]  = '{1, 0, 0, 0, 0, 0, 0, 0,             1, 32'h8C220004, 0, 0,            0, 0, 0, 0};
    vec[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,             0, 32'h8C220004, 0, 0,            0, 0, 0, 0};
    vec[7]  = '{1, 0, 0, 1, 0, 32'h12345678, 0, 0,  0, 32'h8C220004, 0, 0,            0, 0, 0, 0};
    vec[8]  = '{1, 0, 0, 1, 0, 32'h12345678, 1, 0,  0, 32'h8C220004, 0, 0,            0, 1, 0, 32'h12345678};
    vec[9]  = '{1, 0, 0, 0, 0, 0, 0, 0,             0, 32'h8C220004, 1, 0,            0, 0, 0, 0};
    vec[10] = '{1, 0, 0, 0, 0, 0, 1, 32'h12345678,  0, 32'h8C220004, 0, 0,            1, 0, 0, 0};
    vec[11] = '{0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h12345678, 0, 0,            0, 0, 0, 0};
    vec[12] = '{0, 0, 1, 0, 8, 0, 0, 0,             0, 32'h12345678, 0, 0,            0, 0, 0, 0};
    vec[13] = '{0, 0, 1, 0, 8, 0, 1, 32'hCAFEF00D,  0, 32'h12345678, 0, 0,            1, 0, 8, 0};
    vec[14] = '{0, 0, 0, 0, 0, 0, 0, 0,             0, 32'h12345678, 1, 32'hCAFEF00D, 0, 0, 0, 0};
    vec[15] = '{1, 4, 0, 0, 0, 0, 0, 0,             0, 32'h12345678, 0, 32'hCAFEF00D, 0, 0, 0, 0};
    vec[16] = '{1, 4, 0, 0, 0, 0, 1, 32'h20010005,  0, 32'h12345678, 0, 32'hCAFEF00D, 1, 0, 4, 0};
    vec[17] = '{0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h20010005, 0, 32'hCAFEF00D, 0, 0, 0, 0};

    RST = 1'b1; imemREN = 0; imemaddr = 0; dmemREN = 0; dmemWEN = 0;
    dmemaddr = 0; dmemstore = 0; halt = 0; ram_ready = 0; ramload = 0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst.ihit", 32'(ihit), 0);
    check("rst.dhit", 32'(dhit), 0);
    check("rst.imemload", imemload, 0);
    check("rst.dmemload", dmemload, 0);
    check("rst.ramREN", 32'(ramREN), 0);
    check("rst.ramWEN", 32'(ramWEN), 0);
    check("rst.flushed", 32'(flushed), 0);
    check("rst.err", 32'(err), 0);
    cyc(); RST = 1'b0;

    // Per-cycle vector table
    for (int i = 0; i < NV; i++) begin
      cyc();
      imemREN = vec[i].ir; imemaddr = vec[i].ia;
      dmemREN = vec[i].dr; dmemWEN = vec[i].dw;
      dmemaddr = vec[i].da; dmemstore = vec[i].ds;
      ram_ready = vec[i].rdy; ramload = vec[i].rl;
      #1;
      check($sformatf("v%0d.ihit", i),     32'(ihit),   32'(vec[i].e_ihit));
      check($sformatf("v%0d.imemload", i), imemload,    vec[i].e_il);
      check($sformatf("v%0d.dhit", i),     32'(dhit),   32'(vec[i].e_dhit));
      check($sformatf("v%0d.dmemload", i), dmemload,    vec[i].e_dl);
      check($sformatf("v%0d.ramREN", i),   32'(ramREN), 32'(vec[i].e_rr));
      check($sformatf("v%0d.ramWEN", i),   32'(ramWEN), 32'(vec[i].e_rw));
      check($sformatf("v%0d.ramaddr", i),  ramaddr,     vec[i].e_ra);
      check($sformatf("v%0d.ramstore", i), ramstore,    vec[i].e_rs);
    end
    check("tbl.err", 32'(err), 0);

    // Withdrawn fetch: no ihit, but the buffer is still filled
    cyc(); imemREN = 1; imemaddr = 32'h10; ram_ready = 0; #1;
    check("wd.accept_ihit", 32'(ihit), 0);
    cyc(); imemREN = 0; #1;
    check("wd.ramREN", 32'(ramREN), 1);
    check("wd.ramaddr", ramaddr, 32'h10);
    cyc(); ram_ready = 1; ramload = 32'hAAAA5555; #1;
    check("wd.ramREN_ready", 32'(ramREN), 1);
    cyc(); ram_ready = 0; #1;
    check("wd.no_ihit", 32'(ihit), 0);
    check("wd.imemload_held", imemload, 32'h20010005);
    cyc(); imemREN = 1; imemaddr = 32'h10; #1;
    check("wd.ibuf_ihit", 32'(ihit), 1);
    check("wd.ibuf_data", imemload, 32'hAAAA5555);
    check("wd.ibuf_noram", 32'(ramREN), 0);
    cyc(); imemREN = 0;

    // Load timeout with RAM never ready
    cyc(); dmemREN = 1; dmemaddr = 32'h40; #1;
    check("to.accept_dhit", 32'(dhit), 0);
    cyc(); #1;
    check("to.ramaddr", ramaddr, 32'h40);
    n = 0;
    while (ramREN && n < 100) begin
      n++;
      cyc(); #1;
    end
    check("to.strobe_cycles", n, 64);
    check("to.dhit", 32'(dhit), 1);
    check("to.dmemload", dmemload, 32'hBAD1BAD1);
    check("to.err", 32'(err), 1);
    dmemREN = 0;
    cyc(); #1;
    check("to.dhit_pulse", 32'(dhit), 0);
    check("to.err_sticky", 32'(err), 1);
    check("to.no_restart", 32'(ramREN), 0);

    // Halt raised one cycle before the fetch completes
    cyc(); imemREN = 1; imemaddr = 32'h20; #1;
    cyc(); #1;
    check("hl.ramREN", 32'(ramREN), 1);
    halt = 1;
    cyc(); ram_ready = 1; ramload = 32'h11112222; #1;
    check("hl.ramREN_ready", 32'(ramREN), 1);
    cyc(); ram_ready = 0; #1;
    check("hl.ihit", 32'(ihit), 1);
    check("hl.imemload", imemload, 32'h11112222);
    check("hl.flushed_early", 32'(flushed), 0);
    cyc(); #1;
    check("hl.flushed", 32'(flushed), 1);
    viol = 0;
    repeat (5) begin
      cyc(); #1;
      if (ramREN || ramWEN || ihit || dhit || !flushed) viol++;
    end
    check("hl.quiet", viol, 0);

    // Reset out of HALT
    cyc(); RST = 1; #1;
    check("rs.flushed", 32'(flushed), 0);
    check("rs.err", 32'(err), 0);
    cyc(); RST = 0; halt = 0; imemREN = 0;

    // Reset asserted in the middle of a data access
    cyc(); dmemREN = 1; dmemaddr = 32'h50; #1;
    cyc(); #1;
    check("rm.ramREN", 32'(ramREN), 1);
    #2 RST = 1;
    #1;
    check("rm.ramREN_async", 32'(ramREN), 0);
    check("rm.ramaddr", ramaddr, 0);
    check("rm.dhit", 32'(dhit), 0);
    check("rm.dmemload", dmemload, 0);
    check("rm.imemload", imemload, 0);
    cyc(); RST = 0; dmemREN = 0; #1;
    check("rm.no_dhit", 32'(dhit), 0);
    cyc(); imemREN = 1; imemaddr = 32'h20; #1;
    check("rm.ibuf_invalid", 32'(ihit), 0);
    cyc(); #1;
    check("rm.refetch_ramREN", 32'(ramREN), 1);
    check("rm.refetch_addr", ramaddr, 32'h20);
    ram_ready = 1; ramload = 32'h33334444;
    cyc(); ram_ready = 0; imemREN = 0; #1;
    check("rm.refetch_ihit", 32'(ihit), 1);
    check("rm.refetch_data", imemload, 32'h33334444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
Memory-side responder for the datapath/cache handshake. Accepts instruction-fetch and data load/store requests from the datapath and answers with one-cycle ihit/dhit pulses. Arbitrates both request streams onto a single-ported RAM, with data priority. Holds a one-entry instruction buffer and a halt/flush sequence, and sits between the datapath and the RAM model in place of the caches.

Parameters:
ADDR_W, 32, byte address width for the datapath and the RAM.
DATA_W, 32, word width.
TIMEOUT, 64, maximum RAM wait cycles before an access is forced to complete with an error.
ERR_WORD, 32'hBAD1BAD1, load value returned on a timed-out read.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
imemREN  input  1  instruction fetch request
imemaddr  input  ADDR_W  fetch address (word aligned)
ihit  output  1  fetch complete, imemload valid this cycle
imemload  output  DATA_W  fetched instruction
dmemREN  input  1  data load request
dmemWEN  input  1  data store request (REN and WEN never both high)
dmemaddr  input  ADDR_W  data address
dmemstore  input  DATA_W  store data
dhit  output  1  data access complete, dmemload valid for loads
dmemload  output  DATA_W  loaded word
halt  input  1  datapath halted
flushed  output  1  responder quiesced after halt
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  ADDR_W  RAM address
ramstore  output  DATA_W  RAM write data
ramload  input  DATA_W  RAM read data, valid when ram_ready
ram_ready  input  1  RAM completes the current strobe this cycle
err  output  1  sticky, set on any timeout

Behaviour:
- Reset: state IDLE, ihit=dhit=0, imemload=dmemload=0, flushed=0, err=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, ibuf valid=0, wait counter=0.
- FSM states are IDLE, DACC, IACC, HALT.
- IDLE priority order: halt, then (dmemREN|dmemWEN), then imemREN.
  - halt goes to HALT.
  - A data request latches addr, store data and direction, then goes to DACC.
  - imemREN with ibuf hit (valid and tag==imemaddr): ihit=1 combinationally the same cycle with imemload=ibuf data, and the state stays IDLE.
  - imemREN with an ibuf miss latches addr and goes to IACC.
- DACC/IACC:
  - ramREN/ramWEN and ramaddr/ramstore are driven from the latched request and held stable until completion.
  - When ram_ready=1, the next cycle returns to IDLE and pulses dhit or ihit for exactly one cycle.
  - dmemload/imemload are registered from ramload and held until the next hit.
  - For IACC, ibuf gets tag=addr, data=ramload, valid=1.
- Latency: a RAM access that is ready in N cycles produces its hit N+1 cycles after the request is first seen in IDLE. An ibuf hit has 0 latency.
- Back-to-back requests: the cycle a hit is pulsed the state is IDLE, so a new request is evaluated that cycle. A pending fetch stalls behind a data access.
- Store coherence: a store whose address equals the ibuf tag clears ibuf valid in the cycle it is accepted.
- Withdrawn request: if the request that started the access drops before ram_ready, the access still runs to ram_ready and no hit is pulsed. For IACC the ibuf is still filled.
- Timeout: the wait counter increments each cycle in DACC/IACC without ram_ready. When it reaches TIMEOUT-1:
  - strobes drop and the state returns to IDLE;
  - the hit pulses next cycle with load data = ERR_WORD (a store returns dhit with no data);
  - err is set and stays set until RST;
  - ibuf is not filled.
- Counter clears on every state entry.
- HALT: no RAM strobes, ihit/dhit stay 0, flushed=1 from the first cycle in HALT until RST. halt asserted mid-access takes effect only after that access completes.
- RST asserted mid-access drops strobes immediately and discards the access.

Test Plan:
- Fetch 0x00 with ram_ready after 3 cycles, ramload=0x8C220004 -> ramREN high 3 cycles with ramaddr=0x00; ihit for 1 cycle on cycle 4 with imemload=0x8C220004.
- Re-fetch 0x00 immediately -> ihit the same cycle, no ramREN, imemload=0x8C220004.
- dmemWEN to addr 0x00 with data 0x12345678 and imemREN to 0x00 asserted together -> write serviced first (ramWEN, ramstore=0x12345678), dhit; then the fetch misses the invalidated ibuf and issues ramREN.
- Load from 0x40 with ram_ready never asserted, TIMEOUT=64 -> strobe dropped after 64 cycles; dhit with dmemload=0xBAD1BAD1; err=1 and stays 1.
- halt asserted while an IACC is 1 cycle from ram_ready -> ihit delivered, then HALT; flushed=1 and no further strobes despite imemREN=1.
- RST pulsed mid-DACC -> strobes low asynchronously, no dhit, all outputs at reset values, ibuf invalid.
